// File: rtl/ibus_sram_slave.sv
// Instruction-bus responder: word-addressed instruction SRAM with programmable wait states and a loader write port.
// Optional macro IBUS_ERR_CNT_EN adds a saturating bad-fetch counter (err_cnt_o).
module ibus_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ibus_req_i,
  input  logic [31:0] ibus_addr_i,
  output logic [31:0] ibus_data_o,
  output logic        ibus_rvalid_o,
  output logic        ibus_err_o,
  output logic        stallreq_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
`ifdef IBUS_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam int unsigned CW         = 4;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  // One unsigned compare covers both range bounds after rebasing.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (off < SPAN_BYTES) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return AW'(off >> 2);
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           rvalid_q, rvalid_d;
  logic           err_q, err_d;

  logic [31:0]    mem_q [DEPTH_WORDS];
  logic           load_hit;
  logic [AW-1:0]  load_idx;
  logic           rd_ok;
  logic [AW-1:0]  rd_idx;
  logic [31:0]    rd_word;

  assign load_hit = load_we_i && in_range(load_addr_i);
  assign load_idx = word_idx(load_addr_i);
  assign rd_ok    = in_range(addr_q);
  assign rd_idx   = word_idx(addr_q);
  // Write-first bypass when the loader hits the word being read.
  assign rd_word  = (load_hit && (load_idx == rd_idx)) ? load_data_i : mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (load_hit) begin
      mem_q[load_idx] <= load_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (ibus_req_i) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
          addr_d  = ibus_addr_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!ibus_req_i) begin
          state_d = S_IDLE;
        end else if (ibus_addr_i != addr_q) begin
          // PC redirect: drop the old fetch and restart the wait on the new address.
          addr_d = ibus_addr_i;
          cnt_d  = WAIT_LOAD;
        end else if (cnt_q == '0) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          err_d    = !rd_ok;
          data_d   = rd_ok ? rd_word : NOP_INST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign ibus_data_o   = data_q;
  assign ibus_rvalid_o = rvalid_q;
  assign ibus_err_o    = err_q;
  assign stallreq_o    = ibus_req_i & ~rvalid_q;

`ifdef IBUS_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Loader write to ADDR_BASE-4 clears; that address is out of range so it never reaches the SRAM.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load_we_i && (load_addr_i == (ADDR_BASE - 32'd4))) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ibus_sram_slave.sv
// Self-checking bench for ibus_sram_slave: randomized loads/fetches against an array-based reference model.
module tb_ibus_sram_slave;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int unsigned DEPTH   = 4096;
  localparam int unsigned WC      = 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          EXP_LAT = int'(WC) + 2;
  localparam int          MAXW    = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        stallreq;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
`ifdef IBUS_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [DEPTH];

  ibus_sram_slave #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WC),
    .NOP_INST   (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ibus_req_i   (req),
    .ibus_addr_i  (addr),
    .ibus_data_o  (rdata),
    .ibus_rvalid_o(rvalid),
    .ibus_err_o   (err),
    .stallreq_o   (stallreq),
    .load_we_i    (load_we),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data)
`ifdef IBUS_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference decode written straight from the address-map rules in 64-bit arithmetic.
  function automatic logic addr_ok(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(DEPTH) * 4) && (a[1:0] == 2'b00);
  endfunction

  function automatic int unsigned addr_word(input logic [31:0] a);
    return 32'((a - BASE) / 32'd4);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return addr_ok(a) ? mdl[addr_word(a)] : NOP;
  endfunction

  // Stimulus helpers: called and return on a falling edge; they observe but never judge.
  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_we = 1'b0;
    if (addr_ok(a)) mdl[addr_word(a)] = d;
  endtask

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output logic e,
                          output int lat, output logic stall_ok);
    req      = 1'b1;
    addr     = a;
    d        = '0;
    e        = 1'b0;
    lat      = 0;
    stall_ok = 1'b1;
    for (int n = 1; n <= MAXW; n++) begin
      @(negedge clk);
      if (rvalid) begin
        lat = n;
        d   = rdata;
        e   = err;
        if (stallreq !== 1'b0) stall_ok = 1'b0;
        break;
      end else if (stallreq !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({rdata, rvalid, err, stallreq} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h rv=%b err=%b stall=%b required all 0", rdata, rvalid, err, stallreq);
    end
`ifdef IBUS_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic init_mem;
    for (int i = 0; i < 128; i++) do_load(BASE + 32'(i * 4), $urandom);
    do_load(BASE + 32'(DEPTH * 4) - 32'd4, $urandom);
  endtask

  task automatic test_basic;
    logic [31:0] d;
    logic e, sok;
    int lat;
    do_load(BASE, 32'h0010_0093);
    do_fetch(BASE, d, e, lat, sok);
    checks++;
    if (lat != EXP_LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat, EXP_LAT);
    end
    checks++;
    if (d !== 32'h0010_0093 || e !== 1'b0) begin
      errors++;
      $display("FAIL basic_data: got %h err=%b required 00100093 err=0", d, e);
    end
    checks++;
    if (sok !== 1'b1) begin
      errors++;
      $display("FAIL basic_stallreq: stallreq not high while waiting or not low at rvalid");
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0010_0093) begin
      errors++;
      $display("FAIL basic_pulse_hold: got rv=%b data=%h required rv=0 data=00100093", rvalid, rdata);
    end
    // Last word is in range; the next word and a misaligned alias must not disturb word 0.
    do_load(BASE + 32'(DEPTH * 4), 32'hBAD0_0001);
    do_load(BASE + 32'd1, 32'hBAD0_0002);
    do_fetch(BASE, d, e, lat, sok);
    checks++;
    if (d !== exp_data(BASE) || e !== 1'b0) begin
      errors++;
      $display("FAIL ignored_loads: got %h err=%b required %h err=0", d, e, exp_data(BASE));
    end
    do_fetch(BASE + 32'(DEPTH * 4) - 32'd4, d, e, lat, sok);
    checks++;
    if (d !== exp_data(BASE + 32'(DEPTH * 4) - 32'd4) || e !== 1'b0) begin
      errors++;
      $display("FAIL last_word: got %h err=%b required %h err=0", d, e, exp_data(BASE + 32'(DEPTH * 4) - 32'd4));
    end
  endtask

  task automatic test_back_to_back;
    int since, got;
    got   = 0;
    since = 0;
    req   = 1'b1;
    addr  = BASE;
    for (int n = 0; n < 6 * MAXW && got < 6; n++) begin
      @(negedge clk);
      since++;
      if (rvalid) begin
        checks++;
        if (since != EXP_LAT || rdata !== exp_data(BASE + 32'(got * 4))) begin
          errors++;
          $display("FAIL b2b_resp%0d: got gap=%0d data=%h required gap=%0d data=%h",
                   got, since, rdata, EXP_LAT, exp_data(BASE + 32'(got * 4)));
        end
        got++;
        since = 0;
        addr  = BASE + 32'(got * 4);
      end
    end
    req = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses required 6", got);
    end
  endtask

  task automatic test_flush;
    int lat, extra;
    lat   = 0;
    extra = 0;
    req   = 1'b1;
    addr  = BASE + 32'h10;
    @(negedge clk);
    if (rvalid) extra++;
    addr = BASE + 32'h100;
    for (int n = 1; n <= MAXW; n++) begin
      @(negedge clk);
      if (rvalid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != EXP_LAT || rdata !== exp_data(BASE + 32'h100)) begin
      errors++;
      $display("FAIL flush_resp: got lat=%0d data=%h required lat=%0d data=%h",
               lat, rdata, EXP_LAT, exp_data(BASE + 32'h100));
    end
    req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL flush_stale: got %0d extra responses required 0", extra);
    end
  endtask

  task automatic test_withdraw;
    int seen;
    seen = 0;
    req  = 1'b1;
    addr = BASE + 32'h8;
    @(negedge clk);
    req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL withdraw: got %0d responses required 0", seen);
    end
  endtask

  task automatic test_errors;
    logic [31:0] bad [3];
    logic [31:0] d;
    logic e, sok;
    int lat;
    bad[0] = BASE + 32'd2;
    bad[1] = BASE - 32'd4;
    bad[2] = BASE + 32'(DEPTH * 4);
`ifdef IBUS_ERR_CNT_EN
    do_load(BASE - 32'd4, 32'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      do_fetch(bad[i], d, e, lat, sok);
      checks++;
      if (d !== NOP || e !== 1'b1 || lat != EXP_LAT) begin
        errors++;
        $display("FAIL err_fetch%0d: got data=%h err=%b lat=%0d required data=%h err=1 lat=%0d",
                 i, d, e, lat, NOP, EXP_LAT);
      end
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: got err=%b required 0 after response", err);
    end
`ifdef IBUS_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL err_cnt_3: got %0d required 3", err_cnt);
    end
    do_load(BASE - 32'd4, 32'hFFFF_FFFF);
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL err_cnt_clear: got %0d required 0", err_cnt);
    end
`endif
  endtask

  task automatic test_collision;
    logic [31:0] d;
    logic e, sok;
    int lat;
    do_load(BASE + 32'h20, 32'h1234_5678);
    req  = 1'b1;
    addr = BASE + 32'h20;
    repeat (WC + 1) @(negedge clk);
    load_we   = 1'b1;
    load_addr = BASE + 32'h20;
    load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    load_we = 1'b0;
    req     = 1'b0;
    mdl[addr_word(BASE + 32'h20)] = 32'hDEAD_BEEF;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL collision_resp: got rv=%b data=%h required rv=1 data=deadbeef", rvalid, rdata);
    end
    do_fetch(BASE + 32'h20, d, e, lat, sok);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL collision_written: got %h required deadbeef", d);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d, ed;
    logic e, sok, ee;
    int lat, k;
    int unsigned idx;
`ifdef IBUS_ERR_CNT_EN
    int exp_cnt;
    do_load(BASE - 32'd4, 32'h0);
    exp_cnt = 0;
`endif
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, 127);
      k   = int'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) begin
        if (k < 7)      a = BASE + 32'(idx * 4);
        else if (k < 9) a = BASE + 32'(DEPTH * 4) + 32'(idx * 4);
        else            a = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
        do_load(a, $urandom);
      end else begin
        if (k < 6)      a = BASE + 32'(idx * 4);
        else if (k < 8) a = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
        else if (k == 8) a = BASE - 32'((idx + 1) * 4);
        else            a = BASE + 32'(DEPTH * 4) + 32'(idx * 4);
        ed = exp_data(a);
        ee = !addr_ok(a);
        do_fetch(a, d, e, lat, sok);
`ifdef IBUS_ERR_CNT_EN
        if (ee) exp_cnt++;
`endif
        checks++;
        if (d !== ed || e !== ee || lat != EXP_LAT || sok !== 1'b1) begin
          errors++;
          $display("FAIL rand_fetch@%h: got data=%h err=%b lat=%0d stall_ok=%b required data=%h err=%b lat=%0d stall_ok=1",
                   a, d, e, lat, sok, ed, ee, EXP_LAT);
        end
      end
    end
`ifdef IBUS_ERR_CNT_EN
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL rand_err_cnt: got %0d required %0d", err_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic e, sok;
    int lat, seen;
    seen = 0;
    do_load(BASE + 32'h4, 32'hCAFE_0004);
    do_fetch(BASE + 32'h4, d, e, lat, sok);
    req  = 1'b1;
    addr = BASE + 32'h4;
    @(negedge clk);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    checks++;
    if ({rdata, rvalid, err, stallreq} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got data=%h rv=%b err=%b stall=%b required all 0", rdata, rvalid, err, stallreq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_stale: got %0d responses required 0", seen);
    end
    do_fetch(BASE + 32'h4, d, e, lat, sok);
    checks++;
    if (d !== 32'hCAFE_0004 || lat != EXP_LAT) begin
      errors++;
      $display("FAIL reset_mid_refetch: got data=%h lat=%0d required cafe0004 lat=%0d", d, lat, EXP_LAT);
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_basic();
    test_back_to_back();
    test_flush();
    test_withdraw();
    test_errors();
    test_collision();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
